// File: rtl/ntsc_pkg.sv
// Shared types and constants for the NTSC composite timing generator.
// Line-type boundaries are fixed by the broadcast standard, not parametrised.
package ntsc_pkg;

  typedef enum logic [1:0] {LT_EQ, LT_VSYNC, LT_BLANK, LT_SCAN} line_type_e;

  localparam int LINE_W = $clog2(263);

  localparam int SYNC_LVL_DEF  = 0;
  localparam int BLANK_LVL_DEF = 1;
  localparam int BLACK_LVL_DEF = 2;
  localparam int WHITE_LVL_DEF = 7;

  localparam logic [LINE_W-1:0] LINE_VSYNC_FIRST = LINE_W'(3);
  localparam logic [LINE_W-1:0] LINE_EQ2_FIRST   = LINE_W'(6);
  localparam logic [LINE_W-1:0] LINE_BLANK_FIRST = LINE_W'(9);
  localparam logic [LINE_W-1:0] LINE_SCAN_FIRST  = LINE_W'(20);

  localparam logic [LINE_W-1:0] LAST_LINE_INTERLACED  = LINE_W'(262);
  localparam logic [LINE_W-1:0] LAST_LINE_PROGRESSIVE = LINE_W'(261);

  function automatic line_type_e line_type_of(input logic [LINE_W-1:0] line);
    if (line < LINE_VSYNC_FIRST)      return LT_EQ;
    else if (line < LINE_EQ2_FIRST)   return LT_VSYNC;
    else if (line < LINE_BLANK_FIRST) return LT_EQ;
    else if (line < LINE_SCAN_FIRST)  return LT_BLANK;
    else                              return LT_SCAN;
  endfunction

endpackage

// File: rtl/ntsc_line_counter.sv
// Horizontal/line/field sequencing with h_sync and v_sync strobes.
// Interlaced field 0 ends on a half line; field 1 starts mid-way through line 0.
module ntsc_line_counter
  import ntsc_pkg::*;
#(
  parameter int CLK_PER_LINE = 3175,
  parameter int HALF_LINE    = 1588,
  parameter bit INTERLACED   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  output logic [$clog2(CLK_PER_LINE)-1:0] h_cnt_o,
  output logic [LINE_W-1:0]               line_o,
  output logic                            field_o,
  output logic                            h_sync_o,
  output logic                            v_sync_o
);

  localparam int HW = $clog2(CLK_PER_LINE);
  localparam logic [HW-1:0]     H_LAST      = HW'(CLK_PER_LINE - 1);
  localparam logic [HW-1:0]     H_HALF_LAST = HW'(HALF_LINE - 1);
  localparam logic [HW-1:0]     H_HALF      = HW'(HALF_LINE);
  localparam logic [LINE_W-1:0] FIELD_LAST  = INTERLACED ? LAST_LINE_INTERLACED : LAST_LINE_PROGRESSIVE;

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              field_q, field_d;
  logic              half_line, line_end, field_end;

  always_comb begin
    half_line = INTERLACED && !field_q && (line_q == FIELD_LAST);
    line_end  = enable_i && (h_cnt_q == (half_line ? H_HALF_LAST : H_LAST));
    field_end = line_end && (line_q == FIELD_LAST);
    h_cnt_d   = h_cnt_q + 1'b1;
    line_d    = line_q;
    field_d   = field_q;
    if (!enable_i) begin
      h_cnt_d = '0;
      line_d  = '0;
      field_d = 1'b0;
    end else if (field_end) begin
      line_d = '0;
      // Field 1 picks up the second half of line 0.
      if (INTERLACED && !field_q) begin
        field_d = 1'b1;
        h_cnt_d = H_HALF;
      end else begin
        field_d = 1'b0;
        h_cnt_d = '0;
      end
    end else if (line_end) begin
      h_cnt_d = '0;
      line_d  = line_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      line_q  <= '0;
      field_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      line_q  <= line_d;
      field_q <= field_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign line_o   = line_q;
  assign field_o  = field_q;
  assign h_sync_o = line_end;
  assign v_sync_o = field_end;

endmodule

// File: rtl/ntsc_timing_gen.sv
// NTSC composite luma/sync generator: line-type level muxing, pixel window
// decode and a registered output level (one clock behind the counters).
module ntsc_timing_gen
  import ntsc_pkg::*;
#(
  parameter int CLK_PER_LINE = 3175,
  parameter int HALF_LINE    = 1588,
  parameter int FRONT_PORCH  = 75,
  parameter int SYNC_TIP     = 235,
  parameter int EQ_PULSE     = 117,
  parameter int VSYNC_PULSE  = 1353,
  parameter int PIX_DIV      = 4,
  parameter int BASE_X       = 184,
  parameter int RES_H        = 560,
  parameter int BASE_Y       = 30,
  parameter int RES_V        = 400,
  parameter int LUMA_BITS    = 4,
  parameter int OUT_BITS     = 4,
  parameter int SYNC_LVL     = SYNC_LVL_DEF,
  parameter int BLANK_LVL    = BLANK_LVL_DEF,
  parameter int BLACK_LVL    = BLACK_LVL_DEF,
  parameter int WHITE_LVL    = WHITE_LVL_DEF,
  parameter bit INTERLACED   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [LUMA_BITS-1:0] pixel_data,
  output logic                 pixel_req,
  output logic [10:0]          pixel_x,
  output logic [10:0]          pixel_y,
  output logic                 pixel_is_visible,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 field,
  output logic [OUT_BITS-1:0]  ntsc_out
);

  localparam int HW          = $clog2(CLK_PER_LINE);
  localparam int PIX_SHIFT   = $clog2(PIX_DIV);
  localparam int FIELD_LINES = INTERLACED ? RES_V / 2 : RES_V;

  localparam logic [HW-1:0] H_HALF      = HW'(HALF_LINE);
  localparam logic [HW-1:0] H_EQ        = HW'(EQ_PULSE);
  localparam logic [HW-1:0] H_EQ_END    = HW'(HALF_LINE + EQ_PULSE);
  localparam logic [HW-1:0] H_VS        = HW'(VSYNC_PULSE);
  localparam logic [HW-1:0] H_VS_END    = HW'(HALF_LINE + VSYNC_PULSE);
  localparam logic [HW-1:0] H_TIP_START = HW'(FRONT_PORCH);
  localparam logic [HW-1:0] H_TIP_END   = HW'(FRONT_PORCH + SYNC_TIP);
  localparam logic [HW-1:0] H_VIS_START = HW'(BASE_X * PIX_DIV);
  localparam logic [HW-1:0] H_VIS_END   = HW'((BASE_X + RES_H) * PIX_DIV);
  localparam logic [HW-1:0] PIX_MASK    = HW'(PIX_DIV - 1);

  localparam logic [LINE_W-1:0] V_VIS_START = LINE_W'(BASE_Y);
  localparam logic [LINE_W-1:0] V_VIS_END   = LINE_W'(BASE_Y + FIELD_LINES);

  localparam logic [OUT_BITS-1:0]  LVL_SYNC    = OUT_BITS'(SYNC_LVL);
  localparam logic [OUT_BITS-1:0]  LVL_BLANK   = OUT_BITS'(BLANK_LVL);
  localparam logic [OUT_BITS-1:0]  LVL_WHITE   = OUT_BITS'(WHITE_LVL);
  localparam logic [LUMA_BITS:0]   LUMA_BLACK  = (LUMA_BITS+1)'(BLACK_LVL);
  localparam logic [LUMA_BITS:0]   LUMA_WHITE  = (LUMA_BITS+1)'(WHITE_LVL);

  logic [HW-1:0]       h_cnt;
  logic [LINE_W-1:0]   line;
  line_type_e          line_type;
  logic                in_tip, in_eq, in_vs, visible;
  logic [10:0]         line_rel;
  logic [LUMA_BITS:0]  luma_sum;
  logic [OUT_BITS-1:0] luma, level_d, ntsc_q;

  ntsc_line_counter #(
    .CLK_PER_LINE (CLK_PER_LINE),
    .HALF_LINE    (HALF_LINE),
    .INTERLACED   (INTERLACED)
  ) u_line_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .h_cnt_o  (h_cnt),
    .line_o   (line),
    .field_o  (field),
    .h_sync_o (h_sync),
    .v_sync_o (v_sync)
  );

  always_comb begin
    line_type = line_type_of(line);
    in_tip    = (h_cnt >= H_TIP_START) && (h_cnt < H_TIP_END);
    in_eq     = (h_cnt < H_EQ) || ((h_cnt >= H_HALF) && (h_cnt < H_EQ_END));
    in_vs     = (h_cnt < H_VS) || ((h_cnt >= H_HALF) && (h_cnt < H_VS_END));
    visible   = enable && (line_type == LT_SCAN) &&
                (h_cnt >= H_VIS_START) && (h_cnt < H_VIS_END) &&
                (line >= V_VIS_START) && (line < V_VIS_END);
    // One extra bit so the black offset cannot wrap before the white clamp.
    luma_sum  = {1'b0, pixel_data} + LUMA_BLACK;
    luma      = (luma_sum > LUMA_WHITE) ? LVL_WHITE : OUT_BITS'(luma_sum);
    level_d   = LVL_BLANK;
    if (enable) begin
      case (line_type)
        LT_EQ:    if (in_eq) level_d = LVL_SYNC;
        LT_VSYNC: if (in_vs) level_d = LVL_SYNC;
        LT_BLANK: if (in_tip) level_d = LVL_SYNC;
        LT_SCAN: begin
          if (in_tip)       level_d = LVL_SYNC;
          else if (visible) level_d = luma;
        end
        default: level_d = LVL_BLANK;
      endcase
    end
  end

  always_comb begin
    line_rel         = 11'(line) - 11'(BASE_Y);
    pixel_is_visible = visible;
    pixel_req        = visible && ((h_cnt & PIX_MASK) == '0);
    pixel_x          = visible ? (11'(h_cnt >> PIX_SHIFT) - 11'(BASE_X)) : '0;
    pixel_y          = '0;
    if (visible) pixel_y = INTERLACED ? {line_rel[9:0], field} : line_rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ntsc_q <= LVL_BLANK;
    else        ntsc_q <= level_d;
  end

  assign ntsc_out = ntsc_q;

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Scoreboard bench for ntsc_timing_gen using scaled-down timing so that whole
// interlaced frames fit in a short run; an interlaced and a progressive DUT share stimulus.
module tb_ntsc_timing_gen;

  localparam int L = 64, HL = 32, FP = 2, TIP = 5, EQ = 3, VS = 27;
  localparam int PD = 2, BX = 8, RH = 20, BY = 30, RV = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  pixel_data = 4'd0;

  logic        i_req, i_vis, i_hs, i_vs, i_field;
  logic [10:0] i_px, i_py;
  logic [3:0]  i_ntsc;
  logic        p_req, p_vis, p_hs, p_vs, p_field;
  logic [10:0] p_px, p_py;
  logic [3:0]  p_ntsc;

  ntsc_timing_gen #(
    .CLK_PER_LINE(L), .HALF_LINE(HL), .FRONT_PORCH(FP), .SYNC_TIP(TIP),
    .EQ_PULSE(EQ), .VSYNC_PULSE(VS), .PIX_DIV(PD), .BASE_X(BX), .RES_H(RH),
    .BASE_Y(BY), .RES_V(RV), .LUMA_BITS(4), .OUT_BITS(4), .INTERLACED(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
    .pixel_req(i_req), .pixel_x(i_px), .pixel_y(i_py), .pixel_is_visible(i_vis),
    .h_sync(i_hs), .v_sync(i_vs), .field(i_field), .ntsc_out(i_ntsc)
  );

  ntsc_timing_gen #(
    .CLK_PER_LINE(L), .HALF_LINE(HL), .FRONT_PORCH(FP), .SYNC_TIP(TIP),
    .EQ_PULSE(EQ), .VSYNC_PULSE(VS), .PIX_DIV(PD), .BASE_X(BX), .RES_H(RH),
    .BASE_Y(BY), .RES_V(RV), .LUMA_BITS(4), .OUT_BITS(4), .INTERLACED(1'b0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
    .pixel_req(p_req), .pixel_x(p_px), .pixel_y(p_py), .pixel_is_visible(p_vis),
    .h_sync(p_hs), .v_sync(p_vs), .field(p_field), .ntsc_out(p_ntsc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int line; int h; int fld;
    bit hs; bit vs; bit vis; bit req;
    int px; int py;
  } pos_t;

  typedef struct { int lvl; bit chk; } exp_t;

  int   checks = 0, errors = 0;
  int   t = 0;
  int   hs_i_seen = 0, hs_i_exp = 0, hs_p_seen = 0, hs_p_exp = 0;
  int   vq_i[$], vq_p[$];
  exp_t iq[$], pq[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  // Position from absolute cycle count since enable, independent of any counter chain.
  function automatic pos_t model(input bit il, input int tc);
    pos_t m;
    int p;
    if (il) begin
      p = tc % (525 * L);
      if (p < 262 * L + HL) begin
        m.fld = 0;
      end else begin
        m.fld = 1;
        p = p - 262 * L;
      end
    end else begin
      p = tc % (262 * L);
      m.fld = 0;
    end
    m.line = p / L;
    m.h    = p % L;
    m.hs   = (il && m.fld == 0 && m.line == 262) ? (m.h == HL - 1) : (m.h == L - 1);
    m.vs   = m.hs && (m.line == (il ? 262 : 261));
    m.vis  = (m.line >= 20) && (m.h >= BX * PD) && (m.h < (BX + RH) * PD) &&
             (m.line >= BY) && (m.line < BY + (il ? RV / 2 : RV));
    m.req  = m.vis && (m.h % PD == 0);
    m.px   = m.vis ? (m.h / PD - BX) : 0;
    m.py   = m.vis ? (il ? (m.line - BY) * 2 + m.fld : m.line - BY) : 0;
    return m;
  endfunction

  function automatic int level(input pos_t m, input int pd);
    bit tip;
    tip = (m.h >= FP) && (m.h < FP + TIP);
    if (m.line < 3 || (m.line >= 6 && m.line < 9))
      return (m.h < EQ || (m.h >= HL && m.h < HL + EQ)) ? 0 : 1;
    if (m.line < 6)
      return (m.h < VS || (m.h >= HL && m.h < HL + VS)) ? 0 : 1;
    if (m.line < 20) return tip ? 0 : 1;
    if (tip) return 0;
    if (m.vis) return (2 + pd > 7) ? 7 : 2 + pd;
    return 1;
  endfunction

  function automatic bit sel_line(input int ln);
    return ln == 0 || ln == 4 || ln == 10 || ln == 29 || ln == 30 ||
           ln == 31 || ln == 49 || ln == 50 || ln == 261 || ln == 262;
  endfunction

  task automatic start_segment();
    exp_t e;
    t = 0;
    iq.delete(); pq.delete(); vq_i.delete(); vq_p.delete();
    hs_i_seen = 0; hs_i_exp = 0; hs_p_seen = 0; hs_p_exp = 0;
    e.lvl = 1; e.chk = 1'b1;
    iq.push_back(e);
    pq.push_back(e);
  endtask

  task automatic step();
    pos_t mi, mp;
    exp_t e;
    bit   sel_i, sel_p;
    int   pd;
    #1;
    mi = model(1'b1, t);
    mp = model(1'b0, t);
    sel_i = sel_line(mi.line);
    sel_p = sel_line(mp.line);
    if (sel_i) begin
      check("i_visible", int'(i_vis), int'(mi.vis));
      check("i_req", int'(i_req), int'(mi.req));
      check("i_pixel_x", int'(i_px), mi.px);
      check("i_pixel_y", int'(i_py), mi.py);
      check("i_hsync", int'(i_hs), int'(mi.hs));
      check("i_vsync", int'(i_vs), int'(mi.vs));
      check("i_field", int'(i_field), mi.fld);
    end
    if (sel_p) begin
      check("p_visible", int'(p_vis), int'(mp.vis));
      check("p_pixel_y", int'(p_py), mp.py);
      check("p_hsync", int'(p_hs), int'(mp.hs));
      check("p_vsync", int'(p_vs), int'(mp.vs));
      check("p_field", int'(p_field), 0);
    end
    if (mi.vs) vq_i.push_back(t);
    if (mp.vs) vq_p.push_back(t);
    if (i_vs) begin
      check("i_vsync_time", t, (vq_i.size() > 0) ? vq_i.pop_front() : -1);
      $display("vsync interlaced t=%0d field=%0d", t, i_field);
    end
    if (p_vs) begin
      check("p_vsync_time", t, (vq_p.size() > 0) ? vq_p.pop_front() : -1);
      $display("vsync progressive t=%0d field=%0d", t, p_field);
    end
    if (mi.hs) hs_i_exp++;
    if (mp.hs) hs_p_exp++;
    if (i_hs) hs_i_seen++;
    if (p_hs) hs_p_seen++;
    e = iq.pop_front();
    if (e.chk) check("i_ntsc_out", int'(i_ntsc), e.lvl);
    e = pq.pop_front();
    if (e.chk) check("p_ntsc_out", int'(p_ntsc), e.lvl);
    pd = int'($urandom_range(0, 15));
    if (mi.line == 30 && mi.fld == 1 && mi.h == BX * PD) pd = 3;
    if (mi.line == 31 && mi.h == BX * PD) pd = 15;
    pixel_data = 4'(pd);
    e.lvl = level(mi, pd); e.chk = sel_i;
    iq.push_back(e);
    e.lvl = level(mp, pd); e.chk = sel_p;
    pq.push_back(e);
    @(negedge clk);
    t++;
  endtask

  task automatic end_segment();
    check("i_hsync_count", hs_i_seen, hs_i_exp);
    check("p_hsync_count", hs_p_seen, hs_p_exp);
    check("i_vsync_pending", vq_i.size(), 0);
    check("p_vsync_pending", vq_p.size(), 0);
  endtask

  initial begin
    pos_t m;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ntsc_out", int'(i_ntsc), 1);
    check("rst_field", int'(i_field), 0);
    check("rst_hsync", int'(i_hs), 0);
    check("rst_pixel_x", int'(i_px), 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("idle_ntsc_out", int'(i_ntsc), 1);
    check("idle_hsync", int'(i_hs), 0);
    check("idle_req", int'(i_req), 0);
    @(negedge clk);

    // Two full interlaced frames, then into field 1 of the third.
    enable = 1'b1;
    start_segment();
    repeat (2 * 525 * L + 262 * L + 40 * L + 40) step();
    end_segment();

    #1;
    m = model(1'b1, t);
    check("pre_rst_visible", int'(i_vis), int'(m.vis));
    check("pre_rst_field", int'(i_field), m.fld);
    rst_n = 1'b0;
    #1;
    check("async_rst_ntsc_out", int'(i_ntsc), 1);
    check("async_rst_p_ntsc_out", int'(p_ntsc), 1);
    check("async_rst_visible", int'(i_vis), 0);
    check("async_rst_req", int'(i_req), 0);
    check("async_rst_pixel_x", int'(i_px), 0);
    check("async_rst_pixel_y", int'(i_py), 0);
    check("async_rst_field", int'(i_field), 0);
    check("async_rst_hsync", int'(i_hs), 0);
    repeat (2) @(negedge clk);

    rst_n = 1'b1;
    start_segment();
    repeat (50 * L) step();
    end_segment();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
